// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR unit with trap/mret update and irq pending
// Counters, their shadows and mcountinhibit are built only when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int unsigned HART_ID   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_ra_id,
  output logic [XLEN-1:0] csr_rd,
  output logic            csr_ill_id,
  input  logic            csr_wr_intent_id,
  input  logic            csr_we_ex,
  input  logic [1:0]      csr_op_ex,
  input  logic [11:0]     csr_wa_ex,
  input  logic [XLEN-1:0] csr_wd_ex,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_en,
  input  logic            instret_inc,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending,
  output logic [XLEN-1:0] mstatus_o
);

  if (XLEN != 32 || CNT_W < 33 || CNT_W > 64) begin : g_bad_param
    $error("csr_unit: XLEN must be 32 and CNT_W within 33..64");
  end

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic            mtip_q, meip_q, irq_pending_q;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus_val, mie_val, mip_val, wval, tvec_base;
  logic [XLEN:0]   rd_id, old_ex;
  logic            wr_en;

`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic             inh_cy_q, inh_cy_d, inh_ir_q, inh_ir_d;
  logic [63:0]      cyc_ext, ins_ext;

  assign cyc_ext = 64'(mcycle_q);
  assign ins_ext = 64'(minstret_q);
`endif

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mie_val     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
  assign mip_val     = {20'b0, meip_q, 3'b0, mtip_q, 7'b0};

  // Returns {implemented, data}; shared by the ID read port and the EX read-modify-write.
  function automatic logic [XLEN:0] csr_read(input logic [11:0] a);
    logic [XLEN:0] r;
    r = {1'b1, {XLEN{1'b0}}};
    case (a)
      12'h300: r[XLEN-1:0] = mstatus_val;
      12'h304: r[XLEN-1:0] = mie_val;
      12'h305: r[XLEN-1:0] = mtvec_q;
      12'h340: r[XLEN-1:0] = mscratch_q;
      12'h341: r[XLEN-1:0] = mepc_q;
      12'h342: r[XLEN-1:0] = mcause_q;
      12'h343: r[XLEN-1:0] = mtval_q;
      12'h344: r[XLEN-1:0] = mip_val;
      12'hF14: r[XLEN-1:0] = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      12'h320:          r[XLEN-1:0] = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
      12'hB00, 12'hC00: r[XLEN-1:0] = cyc_ext[31:0];
      12'hB80, 12'hC80: r[XLEN-1:0] = cyc_ext[63:32];
      12'hB02, 12'hC02: r[XLEN-1:0] = ins_ext[31:0];
      12'hB82, 12'hC82: r[XLEN-1:0] = ins_ext[63:32];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    rd_id      = csr_read(csr_ra_id);
    csr_rd     = rd_id[XLEN-1:0];
    csr_ill_id = ~rd_id[XLEN] | (csr_wr_intent_id & (csr_ra_id[11:10] == 2'b11));
  end

  always_comb begin
    old_ex = csr_read(csr_wa_ex);
    case (csr_op_ex)
      2'b10:   wval = old_ex[XLEN-1:0] | csr_wd_ex;
      2'b11:   wval = old_ex[XLEN-1:0] & ~csr_wd_ex;
      default: wval = csr_wd_ex;
    endcase
    wr_en = csr_we_ex & (csr_op_ex != 2'b00) & old_ex[XLEN] & ~trap_en & ~mret_en;
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_en) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_wa_ex)
        12'h300: begin mie_d = wval[3]; mpie_d = wval[7]; end
        12'h304: begin mtie_d = wval[7]; meie_d = wval[11]; end
        12'h305: mtvec_d = {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
        12'h340: mscratch_d = wval;
        12'h341: mepc_d = {wval[XLEN-1:2], 2'b00};
        12'h342: mcause_d = wval;
        12'h343: mtval_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q <= 1'b0; mpie_q <= 1'b0; mtie_q <= 1'b0; meie_q <= 1'b0;
      mtip_q <= 1'b0; meip_q <= 1'b0; irq_pending_q <= 1'b0;
      mtvec_q <= MTVEC_RST; mscratch_q <= '0; mepc_q <= '0;
      mcause_q <= '0; mtval_q <= '0;
    end else begin
      mie_q <= mie_d; mpie_q <= mpie_d; mtie_q <= mtie_d; meie_q <= meie_d;
      mtip_q <= irq_timer; meip_q <= irq_ext;
      irq_pending_q <= mie_q & ((mtie_q & mtip_q) | (meie_q & meip_q));
      mtvec_q <= mtvec_d; mscratch_q <= mscratch_d; mepc_q <= mepc_d;
      mcause_q <= mcause_d; mtval_q <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half replaces it and suppresses that counter's increment this cycle.
  always_comb begin
    mcycle_d   = inh_cy_q ? mcycle_q : mcycle_q + CNT_W'(1);
    minstret_d = (instret_inc & ~inh_ir_q) ? minstret_q + CNT_W'(1) : minstret_q;
    inh_cy_d   = inh_cy_q;
    inh_ir_d   = inh_ir_q;
    if (wr_en) begin
      case (csr_wa_ex)
        12'h320: begin inh_cy_d = wval[0]; inh_ir_d = wval[2]; end
        12'hB00: mcycle_d   = CNT_W'({cyc_ext[63:32], wval});
        12'hB80: mcycle_d   = CNT_W'({wval, cyc_ext[31:0]});
        12'hB02: minstret_d = CNT_W'({ins_ext[63:32], wval});
        12'hB82: minstret_d = CNT_W'({wval, ins_ext[31:0]});
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q <= '0; minstret_q <= '0; inh_cy_q <= 1'b0; inh_ir_q <= 1'b0;
    end else begin
      mcycle_q <= mcycle_d; minstret_q <= minstret_d;
      inh_cy_q <= inh_cy_d; inh_ir_q <= inh_ir_d;
    end
  end
`endif

  assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
                       ? tvec_base + {{(XLEN-7){1'b0}}, trap_cause[4:0], 2'b00} : tvec_base;
  assign mepc_o      = mepc_q;
  assign mstatus_o   = mstatus_val;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit with a behavioural CSR model
module tb_csr_unit;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
  localparam int unsigned HART = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_ra_id, csr_wa_ex;
  logic [31:0] csr_rd, csr_wd_ex, trap_cause, trap_pc, trap_val, trap_target, mepc_o, mstatus_o;
  logic        csr_ill_id, csr_wr_intent_id, csr_we_ex, trap_en, mret_en;
  logic        instret_inc, irq_timer, irq_ext, irq_pending;
  logic [1:0]  csr_op_ex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .CNT_W(64), .MTVEC_RST(MTVEC_RST), .HART_ID(HART)) dut (
    .clk(clk), .rst_n(rst_n), .csr_ra_id(csr_ra_id), .csr_rd(csr_rd), .csr_ill_id(csr_ill_id),
    .csr_wr_intent_id(csr_wr_intent_id), .csr_we_ex(csr_we_ex), .csr_op_ex(csr_op_ex),
    .csr_wa_ex(csr_wa_ex), .csr_wd_ex(csr_wd_ex), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret_en(mret_en), .instret_inc(instret_inc),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .trap_target(trap_target), .mepc_o(mepc_o),
    .irq_pending(irq_pending), .mstatus_o(mstatus_o)
  );

  // Reference model state
  logic        m_mie, m_mpie, m_irqp;
  logic [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
  logic [63:0] m_cyc, m_ins;

  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7)};
      12'h304: return {1'b1, m_mie_reg};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'h344: return {1'b1, m_mip};
      12'hF14: return {1'b1, 32'(HART)};
`ifdef CSR_COUNTERS_EN
      12'h320: return {1'b1, m_inh};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
`endif
      default: return 33'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_target();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && trap_cause[31]) return base + 32'(trap_cause[4:0]) * 4;
    return base;
  endfunction

  function automatic void model_step();
    logic [32:0] r;
    logic [31:0] old, nv;
    logic [63:0] cyc0, ins0;
    logic        irqp_n;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_irqp = 0; m_mie_reg = 0; m_mip = 0; m_mtvec = MTVEC_RST;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    irqp_n = m_mie && ((m_mie_reg & m_mip) != 0);
    cyc0 = m_cyc; ins0 = m_ins;
    if (!m_inh[0]) m_cyc = m_cyc + 1;
    if (instret_inc && !m_inh[2]) m_ins = m_ins + 1;
    if (trap_en) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret_en) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (csr_we_ex && csr_op_ex != 2'b00) begin
      r = model_read(csr_wa_ex); old = r[31:0];
      nv = (csr_op_ex == 2'b01) ? csr_wd_ex : (csr_op_ex == 2'b10) ? (old | csr_wd_ex) : (old & ~csr_wd_ex);
      case (csr_wa_ex)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv & 32'h880;
        12'h305: m_mtvec = (nv[1:0] >= 2'd2) ? (nv & ~32'h3) : nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
`ifdef CSR_COUNTERS_EN
        12'h320: m_inh = nv & 32'h5;
        12'hB00: m_cyc = {cyc0[63:32], nv};
        12'hB80: m_cyc = {nv, cyc0[31:0]};
        12'hB02: m_ins = {ins0[63:32], nv};
        12'hB82: m_ins = {nv, ins0[31:0]};
`endif
        default: ;
      endcase
    end
    m_mip = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
    m_irqp = irqp_n;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_wr_intent_id = 0; csr_we_ex = 0; csr_op_ex = 0; csr_wa_ex = 0; csr_wd_ex = 0;
    trap_en = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret_en = 0; instret_inc = 0;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_we_ex = 1; csr_op_ex = op; csr_wa_ex = a; csr_wd_ex = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); irq_timer = 0; irq_ext = 0; csr_ra_id = 12'h305; rst_n = 0;
    trap_en = 1; trap_cause = 32'h8000_0003; trap_pc = 32'h4444; csr_we_ex = 1; csr_op_ex = 2'b01; csr_wa_ex = 12'h340; csr_wd_ex = 32'h55;
    step(); step();
    rst_n = 1; idle(); #1;
    checks++; if (csr_rd !== 32'h100) begin errors++; $display("FAIL reset_mtvec: got %h want %h", csr_rd, 32'h100); end
    checks++; if (csr_ill_id !== 1'b0) begin errors++; $display("FAIL reset_mtvec_ill: got %b want 0", csr_ill_id); end
    checks++; if (mstatus_o !== 32'h1800) begin errors++; $display("FAIL reset_mstatus: got %h want %h", mstatus_o, 32'h1800); end
    checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h want 0", mepc_o); end
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_pending); end
    csr_ra_id = 12'h340; #1;
    checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL reset_mscratch: got %h want 0", csr_rd); end
    csr_ra_id = 12'hF14; #1;
    checks++; if (csr_rd !== 32'(HART)) begin errors++; $display("FAIL hartid: got %h want %h", csr_rd, 32'(HART)); end
  endtask

  task automatic test_trap_vectored();
    csr_op(2'b01, 12'h305, 32'h2001);
    csr_op(2'b10, 12'h300, 32'h8);
    csr_ra_id = 12'h305; #1;
    checks++; if (csr_rd !== 32'h2001) begin errors++; $display("FAIL mtvec_write: got %h want %h", csr_rd, 32'h2001); end
    trap_en = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1237; trap_val = 32'hABC; #1;
    checks++; if (trap_target !== 32'h201C) begin errors++; $display("FAIL trap_target_vec: got %h want %h", trap_target, 32'h201C); end
    trap_cause = 32'h0000_0002; #1;
    checks++; if (trap_target !== 32'h2000) begin errors++; $display("FAIL trap_target_exc: got %h want %h", trap_target, 32'h2000); end
    trap_cause = 32'h8000_0007;
    step(); idle();
    checks++; if (mepc_o !== 32'h1234) begin errors++; $display("FAIL trap_mepc: got %h want %h", mepc_o, 32'h1234); end
    checks++; if (mstatus_o !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h want %h", mstatus_o, 32'h1880); end
    csr_ra_id = 12'h342; #1;
    checks++; if (csr_rd !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause: got %h want %h", csr_rd, 32'h8000_0007); end
  endtask

  task automatic test_priority();
    csr_op(2'b01, 12'h340, 32'h1111);
    csr_we_ex = 1; csr_op_ex = 2'b01; csr_wa_ex = 12'h340; csr_wd_ex = 32'hDEAD;
    trap_en = 1; trap_cause = 32'h5; trap_pc = 32'h800; trap_val = 32'h77;
    step(); idle(); csr_ra_id = 12'h340; #1;
    checks++; if (csr_rd !== 32'h1111) begin errors++; $display("FAIL prio_trap_mscratch: got %h want %h", csr_rd, 32'h1111); end
    checks++; if (mepc_o !== 32'h800) begin errors++; $display("FAIL prio_trap_mepc: got %h want %h", mepc_o, 32'h800); end
    csr_we_ex = 1; csr_op_ex = 2'b01; csr_wa_ex = 12'h340; csr_wd_ex = 32'hBEEF; mret_en = 1;
    step(); idle(); #1;
    checks++; if (csr_rd !== 32'h1111) begin errors++; $display("FAIL prio_mret_mscratch: got %h want %h", csr_rd, 32'h1111); end
    checks++; if (mstatus_o !== 32'h1880) begin errors++; $display("FAIL prio_mret_mstatus: got %h want %h", mstatus_o, 32'h1880); end
  endtask

  task automatic test_irq_mret();
    csr_op(2'b10, 12'h300, 32'h8);
    csr_op(2'b10, 12'h304, 32'h80);
    irq_timer = 1; #1;
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_lat0: got %b want 0", irq_pending); end
    step();
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_lat1: got %b want 0", irq_pending); end
    step();
    checks++; if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_lat2: got %b want 1", irq_pending); end
    csr_ra_id = 12'h344; #1;
    checks++; if (csr_rd !== 32'h80) begin errors++; $display("FAIL mip_read: got %h want %h", csr_rd, 32'h80); end
    trap_en = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h300;
    step(); idle(); step();
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", irq_pending); end
    mret_en = 1; step(); idle();
    checks++; if (mstatus_o !== 32'h1888) begin errors++; $display("FAIL mret_mstatus: got %h want %h", mstatus_o, 32'h1888); end
    irq_timer = 0; step(); step();
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq_pending); end
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    logic [31:0] v;
    csr_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_op(2'b01, 12'hB80, 32'h0);
    step(); step();
    csr_ra_id = 12'hB80; #1;
    checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL mcycleh_carry: got %h want 1", csr_rd); end
    csr_ra_id = 12'hB00; #1;
    checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL mcycle_wrap: got %h want 1", csr_rd); end
    csr_ra_id = 12'hC80; #1;
    checks++; if (csr_rd !== 32'h1) begin errors++; $display("FAIL cycleh_shadow: got %h want 1", csr_rd); end
    csr_op(2'b01, 12'h320, 32'h1);
    csr_op(2'b01, 12'hB02, 32'h0);
    csr_ra_id = 12'hB00; #1; v = csr_rd;
    for (int i = 0; i < 3; i++) begin instret_inc = 1; step(); end
    idle(); step(); #1;
    checks++; if (csr_rd !== v) begin errors++; $display("FAIL mcycle_inhibit: got %h want %h", csr_rd, v); end
    csr_ra_id = 12'hC02; #1;
    checks++; if (csr_rd !== 32'h3) begin errors++; $display("FAIL minstret_count: got %h want 3", csr_rd); end
    csr_op(2'b01, 12'h320, 32'h0);
  endtask
`else
  task automatic test_unimpl_counters();
    csr_ra_id = 12'hB00; #1;
    checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL unimpl_b00_data: got %h want 0", csr_rd); end
    checks++; if (csr_ill_id !== 1'b1) begin errors++; $display("FAIL unimpl_b00_ill: got %b want 1", csr_ill_id); end
  endtask
`endif

  task automatic test_illegal();
    csr_ra_id = 12'hF14; csr_wr_intent_id = 1; #1;
    checks++; if (csr_ill_id !== 1'b1) begin errors++; $display("FAIL ro_write_ill: got %b want 1", csr_ill_id); end
    csr_wr_intent_id = 0; #1;
    checks++; if (csr_ill_id !== 1'b0) begin errors++; $display("FAIL ro_read_ill: got %b want 0", csr_ill_id); end
    csr_ra_id = 12'h7C0; #1;
    checks++; if (csr_ill_id !== 1'b1 || csr_rd !== 32'h0) begin errors++; $display("FAIL unimpl_7c0: got ill=%b rd=%h want ill=1 rd=0", csr_ill_id, csr_rd); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                                12'hF14, 12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'h7C0};
    logic [32:0] r;
    for (int n = 0; n < 600; n++) begin
      idle();
      csr_ra_id = addrs[$urandom_range(0, 15)]; csr_wr_intent_id = 1'($urandom_range(0, 1));
      csr_we_ex = 1'($urandom_range(0, 1)); csr_op_ex = 2'($urandom_range(0, 3));
      csr_wa_ex = addrs[$urandom_range(0, 15)]; csr_wd_ex = $urandom();
      trap_en = ($urandom_range(0, 7) == 0); mret_en = ($urandom_range(0, 7) == 0);
      trap_cause = $urandom(); trap_pc = $urandom(); trap_val = $urandom();
      instret_inc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      #1;
      r = model_read(csr_ra_id);
      checks++; if (csr_rd !== r[31:0]) begin errors++; $display("FAIL rnd_rd[%0d] addr %h: got %h want %h", n, csr_ra_id, csr_rd, r[31:0]); end
      checks++; if (csr_ill_id !== (!r[32] || (csr_wr_intent_id && csr_ra_id[11:10] == 2'b11))) begin errors++; $display("FAIL rnd_ill[%0d] addr %h: got %b", n, csr_ra_id, csr_ill_id); end
      checks++; if (trap_target !== model_target()) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", n, trap_target, model_target()); end
      r = model_read(12'h300);
      checks++; if (mstatus_o !== r[31:0]) begin errors++; $display("FAIL rnd_mstatus[%0d]: got %h want %h", n, mstatus_o, r[31:0]); end
      checks++; if (mepc_o !== m_mepc) begin errors++; $display("FAIL rnd_mepc[%0d]: got %h want %h", n, mepc_o, m_mepc); end
      checks++; if (irq_pending !== m_irqp) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq_pending, m_irqp); end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_trap_vectored();
    test_priority();
    test_irq_mret();
`ifdef CSR_COUNTERS_EN
    test_counters();
`else
    test_unimpl_counters();
`endif
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
